// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable serial pattern detector.
package seq_det_pkg;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic MODE_MEALY = 1'b0;
   localparam logic MODE_MOORE = 1'b1;
   localparam logic OVL_OFF    = 1'b0;
   localparam logic OVL_ON     = 1'b1;

endpackage

// File: rtl/seq_det_matcher.sv
// Masked compare of the history shifted by one bit against the low len bits of the pattern.
module seq_det_matcher #(
   parameter int unsigned MAX_LEN = 8,
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
   input  logic [MAX_LEN-1:0] hist,
   input  logic               in_bit,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               match_c
);

   logic [MAX_LEN:0] shifted;
   logic [MAX_LEN:0] mask;

   // The top bit of the shifted vector drops out of the window, because len never exceeds MAX_LEN.
   always_comb begin
      shifted = {hist, in_bit};
      mask    = '0;
      for (int unsigned i = 0; i <= MAX_LEN; i++) begin
         mask[i] = (32'(len) > i);
      end
      match_c = (((shifted ^ {1'b0, pattern}) & mask) == '0);
   end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap/Moore selection and a saturating hit counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               arstn,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cfg_moore,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               det,
   output logic [CNT_W-1:0]   det_count,
   output logic               cfg_err,
   output logic               active
);

   localparam int unsigned FW = LEN_W + 1;

   logic [0:0]         state;
   logic [0:0]         state_nxt;
   logic [MAX_LEN-1:0] pat_q;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   fill;
   logic               ovl_q;
   logic               moore_q;
   logic               moore_det_q;
   logic               match_c;
   logic               accept_c;
   logic               hit_c;
   logic               len_ok_c;

   seq_det_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
      .hist    (hist),
      .in_bit  (in_bit),
      .pattern (pat_q),
      .len     (len_q),
      .match_c (match_c)
   );

   assign len_ok_c = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   // A cfg_load in the same cycle discards the data bit.
   assign accept_c = (state == S_RUN) && in_valid && !cfg_load;
   assign hit_c    = accept_c && match_c && ((FW'(fill) + FW'(1)) >= FW'(len_q));

   assign det    = (moore_q == MODE_MOORE) ? moore_det_q : hit_c;
   assign active = (state == S_RUN);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cfg_load) state_nxt = len_ok_c ? S_RUN : S_IDLE;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         pat_q       <= '0;
         len_q       <= '0;
         ovl_q       <= 1'b0;
         moore_q     <= 1'b0;
         hist        <= '0;
         fill        <= '0;
         det_count   <= '0;
         cfg_err     <= 1'b0;
         moore_det_q <= 1'b0;
      end else if (cfg_load) begin
         hist        <= '0;
         fill        <= '0;
         det_count   <= '0;
         moore_det_q <= 1'b0;
         cfg_err     <= !len_ok_c;
         if (len_ok_c) begin
            pat_q   <= cfg_pattern;
            len_q   <= cfg_len;
            ovl_q   <= cfg_overlap;
            moore_q <= cfg_moore;
         end
      end else begin
         moore_det_q <= hit_c && (moore_q != MODE_MEALY);
         if (accept_c) begin
            hist <= {hist[MAX_LEN-2:0], in_bit};
            // Non-overlapping hits restart the window so the completing bit is not reused.
            if (hit_c && (ovl_q != OVL_ON)) fill <= '0;
            else if (fill != LEN_W'(MAX_LEN)) fill <= fill + LEN_W'(1);
         end
         if (hit_c && (det_count != {CNT_W{1'b1}})) det_count <= det_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detector_param;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

   logic               clk = 1'b0;
   logic               arstn;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               cfg_moore;
   logic               in_valid;
   logic               in_bit;
   logic               det;
   logic [CNT_W-1:0]   det_count;
   logic               cfg_err;
   logic               active;

   int checks   = 0;
   int failures = 0;

   seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .arstn       (arstn),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_moore   (cfg_moore),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .det         (det),
      .det_count   (det_count),
      .cfg_err     (cfg_err),
      .active      (active)
   );

   always #5 clk = ~clk;

   // Drive one cycle of input at the falling edge and sample det shortly after.
   task automatic step(input logic v, input logic b, output logic d);
      @(negedge clk);
      in_valid = v;
      in_bit   = b;
      #1 d = det;
   endtask

   task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                       input logic ovl, input logic moore);
      @(negedge clk);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ovl;
      cfg_moore   = moore;
      in_valid    = 1'b0;
      @(negedge clk);
      cfg_load = 1'b0;
      #1;
   endtask

   // bits[n-1] is sent first; got[i] is det sampled during the i-th bit.
   task automatic run_bits(input logic [15:0] bits, input int n, output logic [15:0] got);
      logic d;
      got = '0;
      for (int i = 0; i < n; i++) begin
         step(1'b1, bits[n-1-i], d);
         got[i] = d;
      end
   endtask

   task automatic test_reset();
      logic d;
      checks++;
      if (det !== 1'b0 || det_count !== '0 || cfg_err !== 1'b0 || active !== 1'b0) begin
         failures++;
         $display("FAIL reset_values got det=%b cnt=%0d err=%b act=%b exp 0/0/0/0", det, det_count, cfg_err, active);
      end
      @(negedge clk);
      arstn = 1'b1;
      step(1'b1, 1'b1, d);
      checks++;
      if (d !== 1'b0) begin
         failures++;
         $display("FAIL idle_ignores_input got det=%b exp 0", d);
      end
      step(1'b0, 1'b0, d);
   endtask

   task automatic test_mealy_nonoverlap();
      logic [15:0] got;
      logic d;
      load(8'b101, 4'd3, 1'b0, 1'b0);
      checks++;
      if (active !== 1'b1 || cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL load_101_active got act=%b err=%b exp 1/0", active, cfg_err);
      end
      run_bits(16'b10101, 5, got);
      step(1'b0, 1'b0, d);
      checks++;
      if (got !== 16'b00100) begin
         failures++;
         $display("FAIL mealy_nonovl_det got=%b exp=%b", got[4:0], 5'b00100);
      end
      checks++;
      if (det_count !== 2'd1) begin
         failures++;
         $display("FAIL mealy_nonovl_count got=%0d exp=1", det_count);
      end
   endtask

   task automatic test_mealy_overlap();
      logic [15:0] got;
      logic d;
      load(8'b101, 4'd3, 1'b1, 1'b0);
      run_bits(16'b10101, 5, got);
      step(1'b0, 1'b0, d);
      checks++;
      if (got !== 16'b10100) begin
         failures++;
         $display("FAIL mealy_ovl_det got=%b exp=%b", got[4:0], 5'b10100);
      end
      checks++;
      if (det_count !== 2'd2) begin
         failures++;
         $display("FAIL mealy_ovl_count got=%0d exp=2", det_count);
      end
   endtask

   task automatic test_moore();
      logic [6:0] got;
      logic d;
      load(8'b101, 4'd3, 1'b0, 1'b1);
      step(1'b1, 1'b1, got[0]);
      step(1'b1, 1'b0, got[1]);
      step(1'b1, 1'b1, got[2]);
      step(1'b0, 1'b0, got[3]);
      step(1'b0, 1'b0, got[4]);
      checks++;
      if (got[4:0] !== 5'b01000) begin
         failures++;
         $display("FAIL moore_latency got=%b exp=%b", got[4:0], 5'b01000);
      end
      load(8'b101, 4'd3, 1'b0, 1'b1);
      step(1'b1, 1'b1, got[0]);
      step(1'b0, 1'b0, got[1]);
      step(1'b1, 1'b0, got[2]);
      step(1'b0, 1'b0, got[3]);
      step(1'b1, 1'b1, got[4]);
      step(1'b0, 1'b0, got[5]);
      step(1'b0, 1'b0, got[6]);
      checks++;
      if (got !== 7'b0100000) begin
         failures++;
         $display("FAIL moore_gaps got=%b exp=%b", got, 7'b0100000);
      end
      checks++;
      if (det_count !== 2'd1) begin
         failures++;
         $display("FAIL moore_count got=%0d exp=1", det_count);
      end
      step(1'b0, 1'b0, d);
   endtask

   task automatic test_len8_and_illegal();
      logic [15:0] got;
      logic d;
      load(8'hA5, 4'd8, 1'b0, 1'b0);
      run_bits(16'hA5A5, 16, got);
      step(1'b0, 1'b0, d);
      checks++;
      if (got !== 16'h8080) begin
         failures++;
         $display("FAIL len8_det got=%h exp=8080", got);
      end
      checks++;
      if (det_count !== 2'd2) begin
         failures++;
         $display("FAIL len8_count got=%0d exp=2", det_count);
      end
      load(8'hA5, 4'd9, 1'b0, 1'b0);
      checks++;
      if (cfg_err !== 1'b1 || active !== 1'b0 || det_count !== '0) begin
         failures++;
         $display("FAIL illegal_len got err=%b act=%b cnt=%0d exp 1/0/0", cfg_err, active, det_count);
      end
      run_bits(16'hA5A5, 16, got);
      step(1'b0, 1'b0, d);
      checks++;
      if (got !== 16'h0000 || det_count !== '0) begin
         failures++;
         $display("FAIL illegal_no_det got=%h cnt=%0d exp 0000/0", got, det_count);
      end
   endtask

   task automatic test_saturate();
      logic [15:0] got;
      logic d;
      load(8'h01, 4'd1, 1'b0, 1'b0);
      checks++;
      if (cfg_err !== 1'b0 || active !== 1'b1) begin
         failures++;
         $display("FAIL legal_reload got err=%b act=%b exp 0/1", cfg_err, active);
      end
      run_bits(16'h003F, 6, got);
      step(1'b0, 1'b0, d);
      checks++;
      if (got !== 16'h003F) begin
         failures++;
         $display("FAIL len1_det got=%b exp=%b", got[5:0], 6'b111111);
      end
      checks++;
      if (det_count !== 2'd3) begin
         failures++;
         $display("FAIL count_saturate got=%0d exp=3", det_count);
      end
   endtask

   task automatic test_midstream_reset();
      logic d;
      load(8'b101, 4'd3, 1'b0, 1'b0);
      step(1'b1, 1'b1, d);
      step(1'b1, 1'b0, d);
      @(negedge clk);
      in_valid = 1'b0;
      arstn    = 1'b0;
      #1;
      checks++;
      if (active !== 1'b0 || det_count !== '0 || det !== 1'b0) begin
         failures++;
         $display("FAIL midstream_reset got act=%b cnt=%0d det=%b exp 0/0/0", active, det_count, det);
      end
      @(negedge clk);
      arstn = 1'b1;
      load(8'b101, 4'd3, 1'b0, 1'b0);
      step(1'b1, 1'b1, d);
      checks++;
      if (d !== 1'b0) begin
         failures++;
         $display("FAIL after_reset_no_det got det=%b exp 0", d);
      end
      step(1'b0, 1'b0, d);
      checks++;
      if (det_count !== '0 || active !== 1'b1) begin
         failures++;
         $display("FAIL after_reset_state got cnt=%0d act=%b exp 0/1", det_count, active);
      end
   endtask

   initial begin
      arstn       = 1'b0;
      cfg_load    = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_moore   = 1'b0;
      in_valid    = 1'b0;
      in_bit      = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      test_reset();
      test_mealy_nonoverlap();
      test_mealy_overlap();
      test_moore();
      test_len8_and_illegal();
      test_saturate();
      test_midstream_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
